frame_scan_ctrl: RTL

Sequencer for the frame buffer datapath. It owns the frame buffer's `coordinate_X`/`coordinate_Y`/`readWrite` inputs. First it runs a FILL phase, writing one camera frame in raster order as pixels arrive. Then it runs a SCAN phase, stepping through every pixel to read back its 3x3 neighbourhood window, with a valid/ready handshake toward the downstream edge or detection stage. It sits between the camera capture interface and the frame buffer, and presents each window's coordinate alongside the frame buffer's registered window outputs.

---
 rtl/frame_scan_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/frame_scan_ctrl.sv
// Frame buffer sequencer: writes one camera frame in raster order (FILL), then
// reads every 3x3 window back out under a valid/ready handshake (SCAN).
module frame_scan_ctrl #(
  parameter int WIDTH      = 768,
  parameter int HEIGHT     = 512,
  parameter int COORD_BITS = 11
) (
  input  logic                  CAMERA_CLK,
  input  logic                  HRESETn,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  pixel_valid,
  input  logic                  win_ready,
  output logic [COORD_BITS-1:0] coordinate_X,
  output logic [COORD_BITS-1:0] coordinate_Y,
  output logic                  readWrite,
  output logic                  win_valid,
  output logic [COORD_BITS-1:0] win_x,
  output logic [COORD_BITS-1:0] win_y,
  output logic                  busy,
  output logic                  fill_done,
  output logic                  frame_done
);

  localparam logic [COORD_BITS-1:0] LAST_ROW = COORD_BITS'(HEIGHT - 1);
  localparam logic [COORD_BITS-1:0] LAST_COL = COORD_BITS'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [COORD_BITS-1:0]   row_cnt, col_cnt, row_next, col_next;
  logic                    issue_done, issue_done_next;
  logic                    win_valid_next;
  logic [COORD_BITS-1:0]   win_x_next, win_y_next;
  logic                    cnt_at_last, win_at_last, stall;

  assign cnt_at_last = (row_cnt == LAST_ROW) && (col_cnt == LAST_COL);
  assign win_at_last = (win_x == LAST_ROW) && (win_y == LAST_COL);
  assign stall       = win_valid & ~win_ready;

  always_ff @(posedge CAMERA_CLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= IDLE;
      row_cnt    <= '0;
      col_cnt    <= '0;
      issue_done <= 1'b0;
      win_valid  <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
    end else begin
      state      <= state_next;
      row_cnt    <= row_next;
      col_cnt    <= col_next;
      issue_done <= issue_done_next;
      win_valid  <= win_valid_next;
      win_x      <= win_x_next;
      win_y      <= win_y_next;
    end
  end

  always_comb begin
    state_next      = state;
    row_next        = row_cnt;
    col_next        = col_cnt;
    issue_done_next = issue_done;
    win_valid_next  = win_valid;
    win_x_next      = win_x;
    win_y_next      = win_y;
    coordinate_X    = '0;
    coordinate_Y    = '0;
    readWrite       = 1'b0;
    busy            = 1'b0;
    fill_done       = 1'b0;
    frame_done      = 1'b0;

    case (state)
      IDLE: begin
        if (start) state_next = FILL;
      end

      FILL: begin
        busy         = 1'b1;
        readWrite    = 1'b1;
        coordinate_X = row_cnt;
        coordinate_Y = col_cnt;
        if (pixel_valid) begin
          if (cnt_at_last) begin
            fill_done  = 1'b1;
            state_next = SCAN;
            row_next   = '0;
            col_next   = '0;
          end else if (col_cnt == LAST_COL) begin
            col_next = '0;
            row_next = row_cnt + 1'b1;
          end else begin
            col_next = col_cnt + 1'b1;
          end
        end
      end

      SCAN: begin
        busy = 1'b1;
        // While stalled, re-read the presented window so the buffer outputs hold
        if (stall) begin
          coordinate_X = win_x;
          coordinate_Y = win_y;
        end else begin
          coordinate_X = row_cnt;
          coordinate_Y = col_cnt;
        end

        if (win_valid && win_ready && win_at_last) begin
          frame_done      = 1'b1;
          state_next      = IDLE;
          row_next        = '0;
          col_next        = '0;
          issue_done_next = 1'b0;
          win_valid_next  = 1'b0;
          win_x_next      = '0;
          win_y_next      = '0;
        end else if (!stall) begin
          if (!issue_done) begin
            win_valid_next = 1'b1;
            win_x_next     = row_cnt;
            win_y_next     = col_cnt;
            if (cnt_at_last) begin
              issue_done_next = 1'b1;
            end else if (col_cnt == LAST_COL) begin
              col_next = '0;
              row_next = row_cnt + 1'b1;
            end else begin
              col_next = col_cnt + 1'b1;
            end
          end else begin
            win_valid_next = 1'b0;
          end
        end
      end

      default: state_next = IDLE;
    endcase

    // Abort discards the frame: no completion pulse, everything back to idle values
    if (abort) begin
      state_next      = IDLE;
      row_next        = '0;
      col_next        = '0;
      issue_done_next = 1'b0;
      win_valid_next  = 1'b0;
      win_x_next      = '0;
      win_y_next      = '0;
      fill_done       = 1'b0;
      frame_done      = 1'b0;
    end
  end

endmodule
